// File: rtl/addition_subtraction.sv
// Single-precision floating-point adder/subtractor with one output register stage.
// Truncating rounding, subnormals read as zero, Inf/NaN operands raise Exception.
module addition_subtraction (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  input  logic        in_valid,
  output logic        out_valid,
  output logic        Exception,
  output logic [31:0] result
);

  logic [7:0]  a_exp, b_exp;
  logic [23:0] a_sig, b_sig;
  logic        a_sign, b_sign_eff;
  logic        special;
  logic        a_is_big;

  logic        big_sign, small_sign;
  logic [7:0]  big_exp, small_exp, exp_diff;
  logic [23:0] big_sig, small_sig, small_aligned;

  logic [24:0] sum_ext;
  logic [23:0] diff_sig;
  logic [4:0]  lz_count;

  logic [23:0] norm_mant;
  logic [9:0]  norm_exp;
  logic        is_zero, overflow, underflow;
  logic        unused_mant_msb;

  logic [31:0] result_next;
  logic        exception_next;
  logic [31:0] result_reg;
  logic        exception_reg;
  logic        out_valid_reg;

  assign a_exp      = a_operand[30:23];
  assign b_exp      = b_operand[30:23];
  assign a_sign     = a_operand[31];
  assign b_sign_eff = b_operand[31] ^ AddBar_Sub;
  assign special    = (&a_exp) | (&b_exp);

  // Subnormals collapse to a zero significand; their fraction is ignored.
  assign a_sig = (a_exp == 8'd0) ? 24'd0 : {1'b1, a_operand[22:0]};
  assign b_sig = (b_exp == 8'd0) ? 24'd0 : {1'b1, b_operand[22:0]};

  assign a_is_big   = {a_exp, a_sig} >= {b_exp, b_sig};
  assign big_sign   = a_is_big ? a_sign : b_sign_eff;
  assign small_sign = a_is_big ? b_sign_eff : a_sign;
  assign big_exp    = a_is_big ? a_exp : b_exp;
  assign small_exp  = a_is_big ? b_exp : a_exp;
  assign big_sig    = a_is_big ? a_sig : b_sig;
  assign small_sig  = a_is_big ? b_sig : a_sig;

  assign exp_diff      = big_exp - small_exp;
  assign small_aligned = (exp_diff >= 8'd24) ? 24'd0 : (small_sig >> exp_diff);

  assign sum_ext  = {1'b0, big_sig} + {1'b0, small_aligned};
  assign diff_sig = big_sig - small_aligned;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    lz_count = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (diff_sig[i]) lz_count = 5'(23 - i);
    end
  end

  always_comb begin
    norm_mant = 24'd0;
    norm_exp  = 10'd0;
    is_zero   = 1'b0;
    if (big_sign == small_sign) begin
      is_zero = (sum_ext == 25'd0);
      if (sum_ext[24]) begin
        norm_mant = sum_ext[24:1];
        norm_exp  = {2'b00, big_exp} + 10'd1;
      end else begin
        norm_mant = sum_ext[23:0];
        norm_exp  = {2'b00, big_exp};
      end
    end else begin
      is_zero   = (diff_sig == 24'd0);
      norm_mant = diff_sig << lz_count;
      norm_exp  = {2'b00, big_exp} - {5'd0, lz_count};
    end
  end

  // norm_exp is two's complement here; bit 9 marks a negative exponent.
  assign underflow       = norm_exp[9] || (norm_exp == 10'd0);
  assign overflow        = !norm_exp[9] && (norm_exp >= 10'd255);
  assign unused_mant_msb = norm_mant[23];

  always_comb begin
    result_next    = 32'd0;
    exception_next = 1'b0;
    if (special) begin
      exception_next = 1'b1;
    end else if (is_zero) begin
      result_next = 32'd0;
    end else if (overflow) begin
      exception_next = 1'b1;
      result_next    = {big_sign, 8'hFF, 23'd0};
    end else if (underflow) begin
      result_next = {big_sign, 31'd0};
    end else begin
      result_next = {big_sign, norm_exp[7:0], norm_mant[22:0]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_reg    <= 32'd0;
      exception_reg <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= in_valid;
      if (in_valid) begin
        result_reg    <= result_next;
        exception_reg <= exception_next;
      end
    end
  end

  assign result    = result_reg;
  assign Exception = exception_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_addition_subtraction.sv
// Randomised scoreboard bench for addition_subtraction: stimulus pushes expected
// responses, a negedge monitor pops and compares whenever out_valid is high.
module tb_addition_subtraction;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a_operand, b_operand;
  logic        AddBar_Sub;
  logic        in_valid;
  logic        out_valid;
  logic        Exception;
  logic [31:0] result;

  typedef struct packed {
    logic [31:0] res;
    logic        exc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          txn    = 0;
  logic [31:0] last_res = 32'd0;
  logic        last_exc = 1'b0;
  bit          mon_en   = 1'b0;

  addition_subtraction dut (
    .clk        (clk),
    .reset      (reset),
    .a_operand  (a_operand),
    .b_operand  (b_operand),
    .AddBar_Sub (AddBar_Sub),
    .in_valid   (in_valid),
    .out_valid  (out_valid),
    .Exception  (Exception),
    .result     (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: real-number view of the operands, alignment truncation,
  // then normalisation by repeated halving/doubling.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] r, output logic e);
    int     ea, eb, e_big, e_small, d, e_res;
    longint ma, mb, m_big, m_small, v;
    bit     sa, sb, s_big, s_small;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r  = 32'd0;
    e  = 1'b0;
    if (ea == 255 || eb == 255) begin
      e = 1'b1;
      return;
    end
    ma = (ea == 0) ? 64'd0 : (64'h80_0000 + longint'(a[22:0]));
    mb = (eb == 0) ? 64'd0 : (64'h80_0000 + longint'(b[22:0]));
    sa = a[31];
    sb = b[31] ^ sub;
    if (longint'(ea) * 64'd16777216 + ma >= longint'(eb) * 64'd16777216 + mb) begin
      s_big = sa; e_big = ea; m_big = ma; s_small = sb; e_small = eb; m_small = mb;
    end else begin
      s_big = sb; e_big = eb; m_big = mb; s_small = sa; e_small = ea; m_small = ma;
    end
    d = e_big - e_small;
    if (d >= 24) m_small = 0;
    else m_small = m_small / (64'd1 << d);
    v = (s_big == s_small) ? (m_big + m_small) : (m_big - m_small);
    if (v == 0) return;
    e_res = e_big;
    while (v >= 64'd16777216) begin v = v / 2; e_res++; end
    while (v < 64'd8388608)   begin v = v * 2; e_res--; end
    if (e_res >= 255) begin
      e = 1'b1;
      r = {s_big, 8'hFF, 23'd0};
    end else if (e_res <= 0) begin
      r = {s_big, 31'd0};
    end else begin
      r = {s_big, 8'(e_res), v[22:0]};
    end
  endfunction

  function automatic logic [7:0] rand_exp();
    case ($urandom_range(0, 7))
      0:       return 8'h00;
      1:       return 8'hFF;
      2, 3:    return 8'($urandom_range(250, 254));
      default: return 8'($urandom_range(1, 254));
    endcase
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [31:0] r, input logic e);
    exp_t x;
    @(posedge clk);
    #1;
    a_operand  = a;
    b_operand  = b;
    AddBar_Sub = sub;
    in_valid   = 1'b1;
    x.res = r;
    x.exc = e;
    q.push_back(x);
  endtask

  task automatic issue_random();
    logic [31:0] a, b, r;
    logic        e, sub;
    logic [7:0]  ea, eb;
    int          near;
    ea = rand_exp();
    if ($urandom_range(0, 1) == 1) begin
      near = int'(ea) + int'($urandom_range(0, 6)) - 3;
      if (near < 0) near = 0;
      if (near > 255) near = 255;
      eb = 8'(near);
    end else begin
      eb = rand_exp();
    end
    a   = {1'($urandom), ea, 23'($urandom)};
    b   = {1'($urandom), eb, 23'($urandom)};
    sub = 1'($urandom);
    model(a, b, sub, r, e);
    issue(a, b, sub, r, e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    a_operand  = $urandom;
    b_operand  = $urandom;
    AddBar_Sub = 1'($urandom);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 at %0t", $time);
        end else begin
          exp_t x;
          x = q.pop_front();
          txn++;
          $display("txn %0d: result=%08h exc=%0b expected result=%08h exc=%0b",
                   txn, result, Exception, x.res, x.exc);
          check("result", result, x.res);
          check("exception", 32'(Exception), 32'(x.exc));
          last_res = x.res;
          last_exc = x.exc;
        end
      end else begin
        check("hold_result", result, last_res);
        check("hold_exception", 32'(Exception), 32'(last_exc));
      end
    end
  end

  logic [31:0] dir_a   [10] = '{32'h3F800000, 32'h415EB852, 32'h40A00000, 32'h3F800000, 32'h7F800000,
                                32'h7F7FFFFF, 32'h4B800000, 32'h00400000, 32'h3F800000, 32'hFF7FFFFF};
  logic [31:0] dir_b   [10] = '{32'h40000000, 32'h40DEB852, 32'h40A00000, 32'h40000000, 32'h3F800000,
                                32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 32'h7F7FFFFF};
  logic        dir_sub [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] dir_res [10] = '{32'h40400000, 32'h41A70A3D, 32'h00000000, 32'hBF800000, 32'h00000000,
                                32'h7F800000, 32'h4B800000, 32'h3F800000, 32'h00000000, 32'hFF800000};
  logic        dir_exc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b1;
    a_operand  = 32'h3F800000;
    b_operand  = 32'h40000000;
    AddBar_Sub = 1'b0;
    #3;
    check("reset_result", result, 32'd0);
    check("reset_exception", 32'(Exception), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) issue(dir_a[i], dir_b[i], dir_sub[i], dir_res[i], dir_exc[i]);
    idle();
    idle();

    for (int i = 0; i < 4; i++) issue_random();
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7) issue_random();
      else idle();
    end
    idle();
    idle();

    // Reset in mid-stream: the operation in flight must vanish.
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0);
    issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0);
    #6;
    reset = 1'b1;
    #1;
    check("midreset_result", result, 32'd0);
    check("midreset_exception", 32'(Exception), 32'd0);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    last_res = 32'd0;
    last_exc = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 3; i++) idle();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) issue_random();
      else idle();
    end
    for (int i = 0; i < 3; i++) idle();
    check("drain_queue_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addition_subtraction.md
ADDITION_SUBTRACTION -- requirements
Module: addition_subtraction

Interface
REQ-001 The block SHALL use exactly one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port `reset`: input, 1 bit, asynchronous, active-high reset.
REQ-004 Port `a_operand`: input, 32 bits, IEEE-754 single-precision operand A.
REQ-005 Port `b_operand`: input, 32 bits, IEEE-754 single-precision operand B.
REQ-006 Port `AddBar_Sub`: input, 1 bit; 0 computes A+B, 1 computes A-B.
REQ-007 Port `in_valid`: input, 1 bit; operands are sampled on a rising edge where it is 1.
REQ-008 Port `out_valid`: output, 1 bit; high for one cycle when `result` and `Exception` hold a new value.
REQ-009 Port `Exception`: output, 1 bit; flags a special-operand or overflow condition.
REQ-010 Port `result`: output, 32 bits, IEEE-754 single-precision sum or difference.

Function
REQ-011 Latency SHALL be exactly 1 cycle: `out_valid` = `in_valid` delayed one cycle.
REQ-012 Throughput SHALL be one operation per cycle; there is no backpressure.
REQ-013 `result` and `Exception` SHALL hold their last value while `out_valid` = 0.
REQ-014 Subtraction SHALL be performed as addition with B's sign bit inverted.
REQ-015 Special operands: if either operand has exponent 8'hFF (Inf or NaN), `Exception` = 1 and `result` = 32'h0000_0000.
REQ-016 Subnormal inputs (exponent 0) SHALL be treated as signed zero: hidden bit 0, fraction ignored.
REQ-017 Normal operands SHALL form a 24-bit significand {1, fraction}.
REQ-018 The operand with the larger magnitude (exponent, then significand) SHALL be selected as the reference operand.
REQ-019 The smaller operand's significand SHALL be right-shifted by the exponent difference.
REQ-020 A shift of 24 or more SHALL zero the smaller significand.
REQ-021 Same effective sign: significands added; a carry-out shifts the sum right 1 and increments the exponent.
REQ-022 Different effective sign: smaller significand subtracted from larger; result renormalized left by leading-zero count, exponent decremented accordingly.
REQ-023 Rounding SHALL be round-toward-zero: shifted-out bits are discarded, with no guard, round or sticky correction.
REQ-024 The result sign SHALL be the sign of the larger-magnitude operand after the B sign inversion for subtraction.
REQ-025 An exact-zero result SHALL be +0 (32'h0000_0000).
REQ-026 Underflow (normalized exponent at or below 0) SHALL give `result` = signed zero with `Exception` = 0.
REQ-027 Overflow (exponent reaches 255) SHALL give `Exception` = 1 and `result` = {sign, 8'hFF, 23'h0}.
REQ-028 `Exception` SHALL be 0 for all other cases.
REQ-029 The datapath SHALL be combinational from the sampled inputs to a single output register stage.

Reset
REQ-030 While `reset` = 1: `result` = 32'h0, `Exception` = 0, `out_valid` = 0, asynchronously, regardless of `clk`.
REQ-031 An operation sampled in the cycle reset asserts SHALL be discarded: no `out_valid` pulse after reset release.
REQ-032 The first valid output after reset release SHALL appear one cycle after the first `in_valid` sample.

Verification
REQ-033 3F800000 + 40000000 (AddBar_Sub=0) -> `result` 40400000, `Exception` 0, `out_valid` one cycle later.
REQ-034 415EB852 + 40DEB852 -> `result` 41A70A3D (truncated, not 41A70A3E), `Exception` 0.
REQ-035 Subtraction cases, both `Exception` 0:
- 40A00000 - 40A00000 -> `result` 00000000.
- 3F800000 - 40000000 -> `result` BF800000.
REQ-036 Special and overflow cases:
- 7F800000 + 3F800000 -> `Exception` 1, `result` 00000000.
- 7F7FFFFF + 7F7FFFFF -> `Exception` 1, `result` 7F800000.
REQ-037 Mixed magnitudes:
- 4B800000 + 3F800000 (shift 24) -> `result` 4B800000.
- 00400000 + 3F800000 (subnormal) -> `result` 3F800000.
REQ-038 Back-to-back `in_valid` for 4 cycles -> 4 consecutive correct `out_valid` results.
REQ-039 `reset` asserted mid-stream -> outputs are 0 immediately (asynchronously), with no stale `out_valid` after release.
